// File: rtl/pcb_pkg.sv
// Register-map definitions shared by the PCB status monitor register file.
// The per-pool block sits at 4*c; the global registers follow the last pool.
package pcb_pkg;

    typedef enum logic [1:0] {
        REG_FREE = 2'd0,
        REG_MIN  = 2'd1,
        REG_THR  = 2'd2,
        REG_ACNT = 2'd3
    } ch_reg_e;

    localparam int REGS_PER_CH = 4;

    // Global registers are offsets from REGS_PER_CH*NUM_CH
    localparam int REG_STKY = 0;
    localparam int REG_VER  = 1;

    localparam logic [31:0] PCB_VERSION = 32'h0001_0003;

endpackage

// File: rtl/pcb_chan_monitor.sv
// Per-pool free-bufid monitor: minimum watermark, low threshold,
// below-threshold edge detection and a saturating alarm event counter.
module pcb_chan_monitor #(
    parameter int BUFID_W    = 9,
    parameter int CNT_W      = 16,
    parameter int THRESH_DEF = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BUFID_W-1:0] iv_free,
    input  logic               i_min_reload,
    input  logic               i_thr_wr,
    input  logic [BUFID_W-1:0] iv_thr_wdata,
    input  logic               i_acnt_clr,
    output logic               o_rise,
    output logic               o_below_q,
    output logic [BUFID_W-1:0] ov_min,
    output logic [BUFID_W-1:0] ov_thr,
    output logic [CNT_W-1:0]   ov_acnt
);

    logic [BUFID_W-1:0] min_r;
    logic [BUFID_W-1:0] thr_r;
    logic [CNT_W-1:0]   acnt_r;
    logic               below_r;
    logic               below_s;
    logic               rise_s;
    logic [CNT_W-1:0]   acnt_nxt_s;

    // Threshold compare, rising-edge detect and next alarm count
    always_comb begin
        below_s    = (iv_free < thr_r);
        rise_s     = below_s & ~below_r;
        acnt_nxt_s = acnt_r;
        if (i_acnt_clr) begin
            // A clear that coincides with a new event keeps that event
            acnt_nxt_s = rise_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (rise_s && (acnt_r != {CNT_W{1'b1}})) begin
            acnt_nxt_s = acnt_r + CNT_W'(1);
        end else begin
            acnt_nxt_s = acnt_r;
        end
    end

    // Watermark, threshold, counter and below-flag state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            min_r   <= {BUFID_W{1'b1}};
            thr_r   <= BUFID_W'(THRESH_DEF);
            acnt_r  <= {CNT_W{1'b0}};
            below_r <= 1'b0;
        end else begin
            min_r   <= (i_min_reload || (iv_free < min_r)) ? iv_free : min_r;
            thr_r   <= i_thr_wr ? iv_thr_wdata : thr_r;
            acnt_r  <= acnt_nxt_s;
            below_r <= below_s;
        end
    end

    assign o_rise    = rise_s;
    assign o_below_q = below_r;
    assign ov_min    = min_r;
    assign ov_thr    = thr_r;
    assign ov_acnt   = acnt_r;

endmodule

// File: rtl/pcb_status_monitor_regfile.sv
// PCB configuration/status register file: fixed-address decode, read mux with
// a one-cycle registered response, sticky alarm bitmap and per-pool monitors.
module pcb_status_monitor_regfile
    import pcb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int BUFID_W    = 9,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int THRESH_DEF = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_CH*BUFID_W-1:0] iv_free_pkt_bufid_num,
    input  logic [ADDR_W-1:0]         iv_addr,
    input  logic                      i_addr_fixed,
    input  logic [DATA_W-1:0]         iv_wdata,
    input  logic                      i_wr_pcb,
    input  logic                      i_rd_pcb,
    output logic                      o_wr_pcb,
    output logic [ADDR_W-1:0]         ov_addr_pcb,
    output logic                      o_addr_fixed_pcb,
    output logic [DATA_W-1:0]         ov_rdata_pcb,
    output logic [NUM_CH-1:0]         ov_low_alarm
);

    localparam logic [ADDR_W-1:0] CH_END_ADDR = ADDR_W'(REGS_PER_CH * NUM_CH);
    localparam logic [ADDR_W-1:0] STKY_ADDR   = ADDR_W'(REGS_PER_CH * NUM_CH + REG_STKY);
    localparam logic [ADDR_W-1:0] VER_ADDR    = ADDR_W'(REGS_PER_CH * NUM_CH + REG_VER);

    ch_reg_e                        reg_sel_s;
    logic                           in_ch_s;
    logic                           in_map_s;
    logic                           wr_ok_s;
    logic                           rd_ok_s;
    logic                           stky_wr_s;
    logic [NUM_CH-1:0]              ch_sel_s;
    logic [NUM_CH-1:0]              rise_s;
    logic [NUM_CH-1:0]              below_q_s;
    logic [NUM_CH-1:0][DATA_W-1:0]  ch_val_s;
    logic [DATA_W-1:0]              rd_data_s;

    logic                           rsp_vld_r;
    logic                           rsp_fixed_r;
    logic [ADDR_W-1:0]              rsp_addr_r;
    logic [DATA_W-1:0]              rsp_data_r;
    logic [NUM_CH-1:0]              stky_r;

    assign reg_sel_s = ch_reg_e'(iv_addr[1:0]);
    assign in_ch_s   = (iv_addr < CH_END_ADDR);
    assign in_map_s  = in_ch_s || (iv_addr == STKY_ADDR) || (iv_addr == VER_ADDR);
    assign wr_ok_s   = i_wr_pcb & i_addr_fixed;
    // A read colliding with a write is dropped
    assign rd_ok_s   = i_rd_pcb & ~i_wr_pcb & i_addr_fixed & in_map_s;
    assign stky_wr_s = wr_ok_s & (iv_addr == STKY_ADDR);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BUFID_W-1:0] free_s;
        logic [BUFID_W-1:0] min_s;
        logic [BUFID_W-1:0] thr_s;
        logic [CNT_W-1:0]   acnt_s;

        assign free_s      = iv_free_pkt_bufid_num[c*BUFID_W +: BUFID_W];
        assign ch_sel_s[c] = in_ch_s && (iv_addr[ADDR_W-1:2] == (ADDR_W-2)'(c));

        pcb_chan_monitor #(
            .BUFID_W    (BUFID_W),
            .CNT_W      (CNT_W),
            .THRESH_DEF (THRESH_DEF)
        ) u_mon (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .iv_free      (free_s),
            .i_min_reload (wr_ok_s & ch_sel_s[c] & (reg_sel_s == REG_MIN)),
            .i_thr_wr     (wr_ok_s & ch_sel_s[c] & (reg_sel_s == REG_THR)),
            .iv_thr_wdata (iv_wdata[BUFID_W-1:0]),
            .i_acnt_clr   (wr_ok_s & ch_sel_s[c] & (reg_sel_s == REG_ACNT)),
            .o_rise       (rise_s[c]),
            .o_below_q    (below_q_s[c]),
            .ov_min       (min_s),
            .ov_thr       (thr_s),
            .ov_acnt      (acnt_s)
        );

        assign ch_val_s[c] = (reg_sel_s == REG_FREE) ? DATA_W'(free_s) :
                             (reg_sel_s == REG_MIN)  ? DATA_W'(min_s)  :
                             (reg_sel_s == REG_THR)  ? DATA_W'(thr_s)  :
                                                       DATA_W'(acnt_s);
    end

    // Read data mux over the pool blocks and the global registers
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            rd_data_s = rd_data_s | (ch_sel_s[c] ? ch_val_s[c] : {DATA_W{1'b0}});
        end
        if (iv_addr == STKY_ADDR) begin
            rd_data_s = DATA_W'(stky_r);
        end else if (iv_addr == VER_ADDR) begin
            rd_data_s = DATA_W'(PCB_VERSION);
        end else begin
            rd_data_s = rd_data_s;
        end
    end

    // Read response register, cleared on every cycle without a response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_vld_r   <= 1'b0;
            rsp_fixed_r <= 1'b0;
            rsp_addr_r  <= {ADDR_W{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
        end else if (rd_ok_s) begin
            rsp_vld_r   <= 1'b1;
            rsp_fixed_r <= 1'b1;
            rsp_addr_r  <= iv_addr;
            rsp_data_r  <= rd_data_s;
        end else begin
            rsp_vld_r   <= 1'b0;
            rsp_fixed_r <= 1'b0;
            rsp_addr_r  <= {ADDR_W{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
        end
    end

    // Sticky alarm bitmap: a new event beats a simultaneous write-one-to-clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stky_r <= {NUM_CH{1'b0}};
        end else begin
            stky_r <= (stky_r & ~(stky_wr_s ? iv_wdata[NUM_CH-1:0] : {NUM_CH{1'b0}})) | rise_s;
        end
    end

    assign o_wr_pcb         = rsp_vld_r;
    assign o_addr_fixed_pcb = rsp_fixed_r;
    assign ov_addr_pcb      = rsp_addr_r;
    assign ov_rdata_pcb     = rsp_data_r;
    assign ov_low_alarm     = below_q_s;

endmodule

// File: tb/tb_pcb_status_monitor_regfile.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural register model.
module tb_pcb_status_monitor_regfile;
    import pcb_pkg::*;

    localparam int NUM_CH     = 2;
    localparam int BUFID_W    = 9;
    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 16;
    localparam int THRESH_DEF = 16;
    localparam int STKY_A     = 4 * NUM_CH;
    localparam int VER_A      = 4 * NUM_CH + 1;
    localparam int ACNT_MAX   = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [BUFID_W-1:0]        free_v [NUM_CH];
    logic [NUM_CH*BUFID_W-1:0] free_bus;
    logic [ADDR_W-1:0]         addr;
    logic                      fixed;
    logic [DATA_W-1:0]         wdata;
    logic                      wr;
    logic                      rd;
    logic                      o_wr;
    logic [ADDR_W-1:0]         o_addr;
    logic                      o_fixed;
    logic [DATA_W-1:0]         o_rdata;
    logic [NUM_CH-1:0]         o_alarm;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int unsigned m_min  [NUM_CH];
    int unsigned m_thr  [NUM_CH];
    int unsigned m_acnt [NUM_CH];
    bit          m_bq   [NUM_CH];
    bit          m_stky [NUM_CH];
    bit          m_below, m_rise, m_wr, m_rd;
    int unsigned m_a;
    bit          exp_vld;
    int unsigned exp_addr;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    always_comb begin
        free_bus = '0;
        for (int c = 0; c < NUM_CH; c++) free_bus[c*BUFID_W +: BUFID_W] = free_v[c];
    end

    pcb_status_monitor_regfile #(
        .NUM_CH(NUM_CH), .BUFID_W(BUFID_W), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .CNT_W(CNT_W), .THRESH_DEF(THRESH_DEF)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .iv_free_pkt_bufid_num (free_bus),
        .iv_addr               (addr),
        .i_addr_fixed          (fixed),
        .iv_wdata              (wdata),
        .i_wr_pcb              (wr),
        .i_rd_pcb              (rd),
        .o_wr_pcb              (o_wr),
        .ov_addr_pcb           (o_addr),
        .o_addr_fixed_pcb      (o_fixed),
        .ov_rdata_pcb          (o_rdata),
        .ov_low_alarm          (o_alarm)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int unsigned a);
        logic [31:0] v;
        v = 32'd0;
        if (a < 4 * NUM_CH) begin
            case (a % 4)
                0:       v = 32'(free_v[a / 4]);
                1:       v = m_min[a / 4];
                2:       v = m_thr[a / 4];
                default: v = m_acnt[a / 4];
            endcase
        end else if (a == STKY_A) begin
            for (int c = 0; c < NUM_CH; c++) v[c] = m_stky[c];
        end else begin
            v = PCB_VERSION;
        end
        return v;
    endfunction

    // Reference model: register semantics applied once per clock edge
    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_min[c] = (1 << BUFID_W) - 1;
                m_thr[c] = THRESH_DEF;
                m_acnt[c] = 0;
                m_bq[c] = 1'b0;
                m_stky[c] = 1'b0;
            end
            exp_vld = 1'b0; exp_addr = 0; exp_data = 32'd0;
        end else begin
            m_a  = addr;
            m_wr = wr && fixed;
            m_rd = rd && fixed && !wr && (m_a < 4 * NUM_CH + 2);
            exp_vld  = m_rd;
            exp_addr = m_rd ? m_a : 0;
            exp_data = m_rd ? m_read(m_a) : 32'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_below = (free_v[c] < m_thr[c]);
                m_rise  = m_below && !m_bq[c];
                if (m_wr && m_a == 4 * c + 1) m_min[c] = free_v[c];
                else if (free_v[c] < m_min[c]) m_min[c] = free_v[c];
                if (m_wr && m_a == 4 * c + 2) m_thr[c] = wdata % (1 << BUFID_W);
                if (m_wr && m_a == 4 * c + 3) m_acnt[c] = m_rise ? 1 : 0;
                else if (m_rise && m_acnt[c] < ACNT_MAX) m_acnt[c] = m_acnt[c] + 1;
                if (m_wr && m_a == STKY_A && wdata[c]) m_stky[c] = 1'b0;
                if (m_rise) m_stky[c] = 1'b1;
                m_bq[c] = m_below;
            end
        end
    end

    // Compare process: every output against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rsp_valid", 32'(o_wr), 32'(exp_vld));
            chk("rsp_fixed", 32'(o_fixed), 32'(exp_vld));
            chk("rsp_addr", 32'(o_addr), exp_addr);
            chk("rsp_data", o_rdata, exp_data);
            for (int c = 0; c < NUM_CH; c++) chk("low_alarm", 32'(o_alarm[c]), 32'(m_bq[c]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input int unsigned a, input logic [31:0] exp);
        rd = 1'b1; addr = ADDR_W'(a); fixed = 1'b1;
        cyc();
        rd = 1'b0;
        chk({name, "_vld"}, 32'(o_wr), 32'd1);
        chk({name, "_addr"}, 32'(o_addr), a);
        chk(name, o_rdata, exp);
    endtask

    task automatic wr_reg(input int unsigned a, input logic [31:0] d);
        wr = 1'b1; addr = ADDR_W'(a); wdata = d; fixed = 1'b1;
        cyc();
        wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; fixed = 1'b1; addr = '0; wdata = '0;
        free_v[0] = 9'd100; free_v[1] = 9'd300;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("reset_valid", 32'(o_wr), 32'd0);
        chk("reset_alarm", 32'(o_alarm), 32'd0);
        rst = 1'b0;

        // T1: basic read and non-fixed access
        rd_chk("t1_free0", 0, 32'd100);
        rd = 1'b1; fixed = 1'b0; addr = '0;
        cyc();
        rd = 1'b0; fixed = 1'b1;
        chk("t1_nonfixed_vld", 32'(o_wr), 32'd0);
        chk("t1_nonfixed_data", o_rdata, 32'd0);
        rd_chk("t1_ver", VER_A, PCB_VERSION);

        // T2: minimum watermark and reload
        free_v[0] = 9'd200; cyc();
        free_v[0] = 9'd50;  cyc();
        free_v[0] = 9'd120; cyc();
        rd_chk("t2_min", 1, 32'd50);
        wr_reg(1, 32'd0);
        rd_chk("t2_min_reload", 1, 32'd120);

        // T3: threshold crossings, alarm lag, sticky W1C
        wr_reg(2, 32'd64);
        free_v[0] = 9'd70; cyc();
        chk("t3_alarm_hi", 32'(o_alarm[0]), 32'd0);
        free_v[0] = 9'd60; cyc();
        chk("t3_alarm_lo", 32'(o_alarm[0]), 32'd1);
        free_v[0] = 9'd70; cyc();
        free_v[0] = 9'd60; cyc();
        rd_chk("t3_acnt", 3, 32'd2);
        rd_chk("t3_stky", STKY_A, 32'd1);
        wr_reg(STKY_A, 32'd1);
        rd_chk("t3_stky_clr", STKY_A, 32'd0);

        // T4: counter saturation and clear coinciding with a crossing
        force dut.g_ch[0].u_mon.acnt_r = 16'hFFFF;
        m_acnt[0] = ACNT_MAX;
        free_v[0] = 9'd70;
        #1;
        release dut.g_ch[0].u_mon.acnt_r;
        cyc();
        free_v[0] = 9'd60; cyc();
        rd_chk("t4_acnt_sat", 3, 32'h0000_FFFF);
        free_v[0] = 9'd70; cyc();
        free_v[0] = 9'd60;
        wr_reg(3, 32'd0);
        rd_chk("t4_acnt_clr_rise", 3, 32'd1);

        // T5: write+read collision and out-of-map read
        wr = 1'b1; rd = 1'b1; addr = ADDR_W'(6); wdata = 32'hFFFF_F1FF;
        cyc();
        wr = 1'b0; rd = 1'b0;
        chk("t5_collide_vld", 32'(o_wr), 32'd0);
        rd_chk("t5_thr1", 6, 32'h0000_01FF);
        rd = 1'b1; addr = ADDR_W'(4 * NUM_CH + 2);
        cyc();
        rd = 1'b0;
        chk("t5_unmapped_vld", 32'(o_wr), 32'd0);

        // T6: reset while a read is pending
        rd = 1'b1; addr = '0; rst = 1'b1;
        cyc();
        rd = 1'b0; rst = 1'b0;
        chk("t6_vld", 32'(o_wr), 32'd0);
        chk("t6_data", o_rdata, 32'd0);
        chk("t6_alarm", 32'(o_alarm), 32'd0);
        rd_chk("t6_thr_def", 2, 32'(THRESH_DEF));

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NUM_CH; c++) free_v[c] = BUFID_W'($urandom_range(0, 90));
            rst   = ($urandom_range(0, 299) == 0);
            rd    = ($urandom_range(0, 1) == 1);
            wr    = ($urandom_range(0, 3) == 0);
            fixed = ($urandom_range(0, 7) != 0);
            addr  = ($urandom_range(0, 31) == 0) ? ADDR_W'(32'h4_0002)
                                                 : ADDR_W'($urandom_range(0, 12));
            wdata = $urandom;
            if (addr[1:0] == 2'd2) wdata[8:0] = 9'($urandom_range(0, 100));
            cyc();
        end
        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
